emergency_preempt_requester: RTL

Initiator side of the traffic controller's `emergency` override. Watches a raw siren/beacon detector input, synchronizes and debounces it, and drives `emergency` into `smart_traffic_light`. Treats the controller's `lights == GREEN` as the acknowledgement. Holds, releases and times out the preemption with a cooldown, and reports status and an event count to the supervisor.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/sync_debounce.sv | 28 ++
 rtl/emergency_preempt_requester.sv | 94 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: light encodings and preempt FSM states shared with the traffic controller
package traffic_pkg;
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_REQUEST,
    S_HOLD,
    S_COOLDOWN
  } preempt_state_t;
endpackage

// File: rtl/sync_debounce.sv
// sync_debounce: siren synchronizer chain plus consecutive-high counter with an armed strobe
module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic siren_raw,
  input  logic en,
  output logic siren_s,
  output logic armed
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0] dcnt_q;
  assign siren_s = sync_q[SYNC_STAGES-1];
  // armed fires on the sample that completes the run, so the FSM leaves ARM on that same edge
  assign armed = en & siren_s & (dcnt_q == D_LAST);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync_q <= '0;
      dcnt_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], siren_raw};
      dcnt_q <= (en & siren_s & ~armed) ? dcnt_q + 1'b1 : '0;
    end
endmodule

// File: rtl/emergency_preempt_requester.sv
// emergency_preempt_requester: turns a debounced siren into an emergency request, holds it on green,
// aborts on grant timeout and enforces a cooldown before the next request
module emergency_preempt_requester
  import traffic_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GRANT_TIMEOUT   = 16,
  parameter int MIN_HOLD        = 8,
  parameter int COOLDOWN        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       siren_raw,
  input  logic [2:0] lights,
  input  logic       err_clr,
  output logic       emergency,
  output logic       granted,
  output logic       timeout_err,
  output logic [7:0] event_count
);
  localparam int CMAX = (GRANT_TIMEOUT > MIN_HOLD) ?
    ((GRANT_TIMEOUT > COOLDOWN) ? GRANT_TIMEOUT : COOLDOWN) :
    ((MIN_HOLD > COOLDOWN) ? MIN_HOLD : COOLDOWN);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(GRANT_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MIN_HOLD - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN - 1);
  preempt_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] event_q, event_d;
  logic emergency_q, granted_q, timeout_err_q, timeout_err_d;
  logic siren_s, armed, green, grant, timeout, hold_done, cd_done;
  sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk      (clk),
    .rst      (rst),
    .siren_raw(siren_raw),
    .en       (state_q == S_IDLE || state_q == S_ARM),
    .siren_s  (siren_s),
    .armed    (armed)
  );
  assign green         = lights == LIGHT_GREEN;
  assign grant         = state_q == S_REQUEST && green;
  assign timeout       = state_q == S_REQUEST && !green && cnt_q == TO_LAST;
  // the count holds completed cycles, so MIN_HOLD-1 means the current cycle finishes the minimum
  assign hold_done     = cnt_q == HOLD_LAST;
  assign cd_done       = cnt_q == CD_LAST;
  assign timeout_err_d = timeout | (timeout_err_q & ~err_clr);
  assign event_d       = event_q + 8'(grant && event_q != 8'hff);
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:    state_d = siren_s ? (armed ? S_REQUEST : S_ARM) : S_IDLE;
      S_ARM:     state_d = !siren_s ? S_IDLE : (armed ? S_REQUEST : S_ARM);
      S_REQUEST: begin
        state_d = grant ? S_HOLD : (timeout ? S_COOLDOWN : S_REQUEST);
        cnt_d   = (grant || timeout) ? '0 : cnt_q + 1'b1;
      end
      S_HOLD: begin
        state_d = (hold_done && !siren_s) ? S_COOLDOWN : (!green ? S_REQUEST : S_HOLD);
        cnt_d   = (state_d != S_HOLD) ? '0 : (hold_done ? cnt_q : cnt_q + 1'b1);
      end
      S_COOLDOWN: begin
        state_d = cd_done ? S_IDLE : S_COOLDOWN;
        cnt_d   = cd_done ? '0 : cnt_q + 1'b1;
      end
      default:   state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      event_q       <= '0;
      emergency_q   <= 1'b0;
      granted_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      event_q       <= event_d;
      emergency_q   <= state_d == S_REQUEST || state_d == S_HOLD;
      granted_q     <= state_d == S_HOLD;
      timeout_err_q <= timeout_err_d;
    end
  assign emergency   = emergency_q;
  assign granted     = granted_q;
  assign timeout_err = timeout_err_q;
  assign event_count = event_q;
endmodule
